data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the synchronous word-addressed data memory (XLEN-wide words, TAM entries, one-cycle registered read, read and write mutually exclusive per cycle).
- Port 0 is the core load/store path; port 1 is the program loader/debug path.
- Arbitrates round-robin, validates addresses, drives the memory's address/data/write-enable, and returns a response pulse with read data or an error flag.

Parameters:
- XLEN, 32, data word width
- TAM, 16, number of memory words
- ADDRESSLEN, 32, byte address width

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- p0_req, p1_req  input  1  request valid (held until accepted)
- p0_ready, p1_ready  output  1  request accepted this cycle
- p0_we, p1_we  input  1  1=write, 0=read
- p0_addr, p1_addr  input  ADDRESSLEN  byte address
- p0_wdata, p1_wdata  input  XLEN  write data
- p0_rsp_valid, p1_rsp_valid  output  1  one-cycle response pulse
- rsp_err  output  1  response error (qualified by either rsp_valid)
- rsp_rdata  output  XLEN  read data (qualified by rsp_valid of a read)
- mem_address  output  ADDRESSLEN  to memory address
- mem_data  output  XLEN  to memory data
- mem_iWrite  output  1  to memory write enable
- mem_out  input  XLEN  from memory registered read data

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset goes to IDLE, last_grant=1, all registered request fields cleared.
- IDLE:
  - Grant the only requester when exactly one requests.
  - When both request, grant the port not equal to last_grant.
  - pN_ready=1 combinationally for the granted port only. Both readies are never high together.
  - On accept: latch we, addr, wdata and owner; set last_grant=owner; compute err_q = (addr[1:0]!=0) || (addr[ADDRESSLEN-1:2] >= TAM); go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - mem_address=addr_q, mem_data=wdata_q.
  - mem_iWrite = we_q && !err_q && !rst.
  - Always go to RESP.
- RESP:
  - mem_address=addr_q, mem_iWrite=0, so mem_out holds the word at addr_q.
  - Owner's rsp_valid=1 for exactly this cycle; rsp_err=err_q.
  - rsp_rdata = mem_out for a non-error read, else 0.
  - Go to IDLE.
- Outside ACCESS: mem_iWrite=0; mem_address and mem_data hold the latched values.
- Outputs during and after reset: p0_ready=p1_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_iWrite=0.
- Latency and throughput: accept at cycle T (IDLE), memory operation at T+1 edge, response at T+2. Next accept earliest at T+3, so at most one transaction per 3 cycles.
- Error handling: an erroneous write never asserts mem_iWrite. An erroneous read returns err=1 and rdata=0. The error response has the same timing as a normal response.
- Reset mid-operation: at any state, reset returns to IDLE at the next edge. The pending response is dropped. A write in ACCESS with rst high is suppressed.
- Request deasserted before accept: nothing is recorded. Requesters must hold req/we/addr/wdata stable until ready.
- Requester re-requesting in the RESP cycle: not accepted until IDLE. Fairness applies against the other port.

Test Plan:
- p0 write addr 0x8, data 0xDEADBEEF, then p0 read 0x8 -> p0_ready at T; mem_iWrite=1 with mem_address=0x8 only in T+1; p0_rsp_valid at T+2 with rdata=0xDEADBEEF, err=0.
- p0 and p1 both request reads continuously from reset -> grants alternate p0, p1, p0, p1, spaced 3 cycles apart; responses arrive on the matching port only.
- p1 write to addr 0x6 (misaligned) and p1 write to 0x40 (word 16 >= TAM) -> mem_iWrite never asserts; p1_rsp_valid with err=1; a follow-up read of word 0 is unchanged.
- rst asserted during ACCESS of a p0 write to 0x4 -> no write occurs (a later read of 0x4 returns the prior value); no rsp_valid; last_grant returns to 1 so p0 wins the next simultaneous request.
- Single requester p1 issues 4 back-to-back reads of 0x0, 0x4, 0x8, 0xC -> accepts every 3 cycles; rdata matches preloaded words; p0 ready and rsp_valid stay 0 throughout.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a synchronous word-addressed data memory.
// Each accepted request runs IDLE -> ACCESS -> RESP, so at most one transaction every three cycles.
module data_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int TAM        = 16,
  parameter int ADDRESSLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [ADDRESSLEN-1:0] p0_addr,
  input  logic [XLEN-1:0]       p0_wdata,
  output logic                  p0_rsp_valid,
  input  logic                  p1_req,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [ADDRESSLEN-1:0] p1_addr,
  input  logic [XLEN-1:0]       p1_wdata,
  output logic                  p1_rsp_valid,
  output logic                  rsp_err,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic [ADDRESSLEN-1:0] mem_address,
  output logic [XLEN-1:0]       mem_data,
  output logic                  mem_iWrite,
  input  logic [XLEN-1:0]       mem_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDRESSLEN-3:0] WORDS = (ADDRESSLEN-2)'(TAM);

  state_t                state;
  logic                  last_grant, owner_q, we_q, err_q;
  logic [ADDRESSLEN-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;

  logic                  gnt0, gnt1, sel_we, sel_err, in_resp;
  logic [ADDRESSLEN-1:0] sel_addr;
  logic [XLEN-1:0]       sel_wdata;

  // On contention the port that did not win last time gets the grant.
  assign gnt0 = (state == IDLE) && !rst && p0_req && (!p1_req || last_grant);
  assign gnt1 = (state == IDLE) && !rst && p1_req && (!p0_req || !last_grant);

  assign p0_ready  = gnt0;
  assign p1_ready  = gnt1;

  assign sel_we    = gnt1 ? p1_we    : p0_we;
  assign sel_addr  = gnt1 ? p1_addr  : p0_addr;
  assign sel_wdata = gnt1 ? p1_wdata : p0_wdata;
  assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[ADDRESSLEN-1:2] >= WORDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: if (gnt0 || gnt1) begin
          owner_q    <= gnt1;
          last_grant <= gnt1;
          we_q       <= sel_we;
          addr_q     <= sel_addr;
          wdata_q    <= sel_wdata;
          err_q      <= sel_err;
          state      <= ACCESS;
        end
        ACCESS:  state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Address stays on the bus through RESP so mem_out keeps showing the accessed word.
  assign mem_address  = addr_q;
  assign mem_data     = wdata_q;
  assign mem_iWrite   = (state == ACCESS) && we_q && !err_q && !rst;

  assign in_resp      = (state == RESP) && !rst;
  assign p0_rsp_valid = in_resp && !owner_q;
  assign p1_rsp_valid = in_resp && owner_q;
  assign rsp_err      = in_resp && err_q;
  assign rsp_rdata    = (in_resp && !we_q && !err_q) ? mem_out : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized scoreboard bench for data_mem_arbiter with a behavioural memory and reference model.
module tb_data_mem_arbiter;
  localparam int XLEN = 32, TAM = 16, AL = 32;

  typedef struct { logic we; logic [AL-1:0] addr; logic [XLEN-1:0] wdata; } txn_t;
  typedef struct { int port; logic err; logic [XLEN-1:0] rdata; int cyc; } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [AL-1:0] p0_addr = '0, p1_addr = '0;
  logic [XLEN-1:0] p0_wdata = '0, p1_wdata = '0;
  logic p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, rsp_err, mem_iWrite;
  logic [XLEN-1:0] rsp_rdata, mem_data;
  logic [XLEN-1:0] mem_out = '0;
  logic [AL-1:0] mem_address;

  data_mem_arbiter #(.XLEN(XLEN), .TAM(TAM), .ADDRESSLEN(AL)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p1_req(p1_req), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_iWrite(mem_iWrite),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory: registered read, write and read exclusive; out-of-range reads return a marker.
  logic [XLEN-1:0] init_words [TAM];
  logic [XLEN-1:0] mem [TAM];
  logic mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (rst && !mem_loaded) begin
      for (int i = 0; i < TAM; i++) mem[i] <= init_words[i];
      mem_loaded <= 1'b1;
    end else if (mem_iWrite) begin
      if (mem_address[AL-1:2] < TAM) mem[mem_address[AL-1:2]] <= mem_data;
    end else begin
      mem_out <= (mem_address[AL-1:2] < TAM) ? mem[mem_address[AL-1:2]] : 32'hBAD0BAD0;
    end
  end

  // Reference model state
  logic [XLEN-1:0] ref_mem [TAM];
  logic ref_loaded = 1'b0;
  rsp_t rspq[$];
  txn_t txq0[$], txq1[$];
  logic model_last = 1'b1;
  logic wr_pend = 1'b0;
  int wr_cyc, last_acc;
  logic have_acc = 1'b0;
  logic [AL-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;

  int m_p;
  logic m_we, m_err;
  logic [AL-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  rsp_t m_r;

  always @(negedge clk) begin
    if (rst) begin
      if (!ref_loaded) begin
        for (int i = 0; i < TAM; i++) ref_mem[i] = init_words[i];
        ref_loaded = 1'b1;
      end
      rspq.delete();
      wr_pend = 1'b0; model_last = 1'b1; have_acc = 1'b0;
      chk("rst_ready", {p1_ready, p0_ready}, 0);
      chk("rst_rsp_valid", {p1_rsp_valid, p0_rsp_valid}, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_iWrite", mem_iWrite, 0);
    end else begin
      // Memory write must happen exactly one cycle after a legal write is accepted
      chk("mem_iWrite", mem_iWrite, wr_pend && (wr_cyc == cyc));
      if (wr_pend && wr_cyc == cyc) begin
        chk("wr_addr", mem_address, wr_addr);
        chk("wr_data", mem_data, wr_data);
        ref_mem[wr_addr[AL-1:2]] = wr_data;
        wr_pend = 1'b0;
      end
      if (p0_ready && p1_ready) chk("both_ready", 1, 0);
      if (p0_ready && !p0_req) chk("p0_ready_no_req", 1, 0);
      if (p1_ready && !p1_req) chk("p1_ready_no_req", 1, 0);
      if (p0_ready ^ p1_ready) begin
        m_p = p1_ready ? 1 : 0;
        if (p0_req && p1_req) chk("fair_grant", m_p, model_last ? 0 : 1);
        if (have_acc) chk("accept_gap_ge3", (cyc - last_acc) >= 3, 1);
        m_we    = m_p ? p1_we : p0_we;
        m_addr  = m_p ? p1_addr : p0_addr;
        m_wdata = m_p ? p1_wdata : p0_wdata;
        m_err   = (m_addr % 4 != 0) || ((m_addr / 4) >= TAM);
        m_r.port  = m_p;
        m_r.err   = m_err;
        m_r.rdata = (!m_we && !m_err) ? ref_mem[m_addr / 4] : '0;
        m_r.cyc   = cyc + 2;
        rspq.push_back(m_r);
        if (m_we && !m_err) begin
          wr_pend = 1'b1; wr_cyc = cyc + 1; wr_addr = m_addr; wr_data = m_wdata;
        end
        model_last = m_p[0];
        last_acc = cyc; have_acc = 1'b1;
      end
      if (rspq.size() > 0 && rspq[0].cyc < cyc) begin
        chk("rsp_missing", 0, 1);
        void'(rspq.pop_front());
      end
      if (p0_rsp_valid || p1_rsp_valid) begin
        if (rspq.size() == 0) chk("rsp_unexpected", {p1_rsp_valid, p0_rsp_valid}, 0);
        else begin
          m_r = rspq.pop_front();
          chk("rsp_port", {p1_rsp_valid, p0_rsp_valid}, (m_r.port == 1) ? 2 : 1);
          chk("rsp_cycle", cyc, m_r.cyc);
          chk("rsp_err", rsp_err, m_r.err);
          chk("rsp_rdata", rsp_rdata, m_r.rdata);
        end
      end
    end
  end

  // Per-port drivers: hold the head transaction until ready, then move on.
  task automatic drv(input int p);
    txn_t t;
    int n;
    forever begin
      @(posedge clk); #1;
      if ((p == 0 ? txq0.size() : txq1.size()) == 0) begin
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
      end else begin
        t = (p == 0) ? txq0[0] : txq1[0];
        if (p == 0) begin p0_req = 1'b1; p0_we = t.we; p0_addr = t.addr; p0_wdata = t.wdata; end
        else        begin p1_req = 1'b1; p1_we = t.we; p1_addr = t.addr; p1_wdata = t.wdata; end
        n = 0;
        do begin @(negedge clk); n++; end while (!(p == 0 ? p0_ready : p1_ready) && n < 200);
        if (n >= 200) chk($sformatf("p%0d_accept_timeout", p), 0, 1);
        if (p == 0) void'(txq0.pop_front()); else void'(txq1.pop_front());
      end
    end
  endtask

  initial drv(0);
  initial drv(1);

  function automatic txn_t mk(input logic we, input logic [AL-1:0] a, input logic [XLEN-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic drain();
    int n = 0;
    while ((txq0.size() != 0 || txq1.size() != 0 || rspq.size() != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) chk("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n, kind;
    logic [AL-1:0] a;
    rst = 1'b1;
    for (int i = 0; i < TAM; i++) init_words[i] = $urandom;
    // Request held during reset must not be accepted
    txq0.push_back(mk(1'b1, 32'h8, 32'hDEADBEEF));
    txq0.push_back(mk(1'b0, 32'h8, 32'h0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    drain();

    // Both ports requesting continuously from reset
    pulse_rst();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      txq0.push_back(mk(1'b0, 32'(i * 4), 32'h0));
      txq1.push_back(mk(1'b0, 32'(i * 4 + 16), 32'h0));
    end
    drain();

    // Erroneous writes from p1, then a read of word 0
    txq1.push_back(mk(1'b1, 32'h6, 32'h11111111));
    txq1.push_back(mk(1'b1, 32'h40, 32'h22222222));
    txq1.push_back(mk(1'b0, 32'h0, 32'h0));
    txq1.push_back(mk(1'b0, 32'h6, 32'h0));
    txq1.push_back(mk(1'b0, 32'h40, 32'h0));
    drain();

    // Reset during ACCESS of a p0 write
    txq0.push_back(mk(1'b1, 32'h4, 32'h12345678));
    n = 0;
    do begin @(negedge clk); n++; end while (!p0_ready && n < 100);
    if (n >= 100) chk("mid_rst_accept_timeout", 0, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    txq0.push_back(mk(1'b0, 32'h4, 32'h0));
    txq1.push_back(mk(1'b0, 32'h4, 32'h0));
    drain();

    // p1 alone, four back-to-back reads
    for (int i = 0; i < 4; i++) txq1.push_back(mk(1'b0, 32'(i * 4), 32'h0));
    drain();

    // Random mix on both ports
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7)       a = 32'($urandom_range(0, TAM - 1) * 4);
      else if (kind == 7) a = 32'($urandom_range(0, TAM - 1) * 4 + $urandom_range(1, 3));
      else                a = 32'((TAM + $urandom_range(0, 15)) * 4);
      if ($urandom_range(0, 1) == 0) txq0.push_back(mk($urandom_range(0, 1) == 1, a, $urandom));
      else                           txq1.push_back(mk($urandom_range(0, 1) == 1, a, $urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
